// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute/memory/writeback sequencer owning the architectural PC.
// Latency: fetch wait + 3 cycles per insn (+>=1 MEM cycle for loads/stores); stalls on imem_ready/dmem_ready.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    output logic                  ir_we,
    input  logic                  insn_is_mem,
    input  logic                  insn_writes_rd,
    input  logic                  insn_halt,
    input  logic                  br_taken,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  retire,
    output logic                  halted,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  r_is_mem;
    logic                  r_rd;
    logic                  r_halt;
    logic                  r_taken;
    logic                  r_imem_req;
    logic                  r_dmem_req;
    logic                  r_rf_we;
    logic                  r_retire;
    logic                  r_halted;
    logic                  r_fault;
    logic [CNT_WIDTH-1:0]  r_retire_count;
    logic [CNT_WIDTH-1:0]  r_taken_count;
    logic                  w_fetch;

    assign w_fetch = (r_state == S_FETCH);

    // Output flops are loaded with the decode of the state being entered, so
    // every output except ir_we is a pure register with no path from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_target       <= RESET_PC;
            r_is_mem       <= 1'b0;
            r_rd           <= 1'b0;
            r_halt         <= 1'b0;
            r_taken        <= 1'b0;
            r_imem_req     <= 1'b1;
            r_dmem_req     <= 1'b0;
            r_rf_we        <= 1'b0;
            r_retire       <= 1'b0;
            r_halted       <= 1'b0;
            r_fault        <= 1'b0;
            r_retire_count <= '0;
            r_taken_count  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state    <= S_EXEC;
                        r_imem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_is_mem <= insn_is_mem;
                    r_rd     <= insn_writes_rd;
                    r_halt   <= insn_halt;
                    r_taken  <= br_taken;
                    r_target <= next_pc;
                    if (insn_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (next_pc[1:0] != 2'b00) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (insn_is_mem) begin
                        r_state    <= S_MEM;
                        r_dmem_req <= 1'b1;
                    end else begin
                        r_state  <= S_WB;
                        r_retire <= 1'b1;
                        r_rf_we  <= insn_writes_rd;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state    <= S_WB;
                        r_dmem_req <= 1'b0;
                        r_retire   <= 1'b1;
                        r_rf_we    <= r_rd;
                    end
                end
                S_WB: begin
                    r_state        <= S_FETCH;
                    r_imem_req     <= 1'b1;
                    r_retire       <= 1'b0;
                    r_rf_we        <= 1'b0;
                    r_pc           <= r_target;
                    r_retire_count <= r_retire_count + 1'b1;
                    if (r_taken) begin
                        r_taken_count <= r_taken_count + 1'b1;
                    end
                end
                S_HALT, S_FAULT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state    <= S_FAULT;
                    r_fault    <= 1'b1;
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_retire   <= 1'b0;
                    r_rf_we    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_pc;
    assign ir_we        = w_fetch & imem_ready;
    assign dmem_req     = r_dmem_req;
    assign rf_we        = r_rf_we;
    assign pc           = r_pc;
    assign retire       = r_retire;
    assign halted       = r_halted;
    assign fault        = r_fault;
    assign retire_count = r_retire_count;
    assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized instruction stream for pc_sequencer, checked against an
// instruction-level model of PC and counter evolution.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        ir_we;
    logic        insn_is_mem;
    logic        insn_writes_rd;
    logic        insn_halt;
    logic        br_taken;
    logic [31:0] next_pc;
    logic        dmem_req;
    logic        dmem_ready;
    logic        rf_we;
    logic [31:0] pc;
    logic        retire;
    logic        halted;
    logic        fault;
    logic [31:0] retire_count;
    logic [31:0] taken_count;

    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_tkn;
    int          n_pass  = 0;
    int          n_total = 0;

    pc_sequencer #(
        .ADDR_WIDTH (32),
        .RESET_PC   (RST_PC),
        .CNT_WIDTH  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .ir_we          (ir_we),
        .insn_is_mem    (insn_is_mem),
        .insn_writes_rd (insn_writes_rd),
        .insn_halt      (insn_halt),
        .br_taken       (br_taken),
        .next_pc        (next_pc),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .rf_we          (rf_we),
        .pc             (pc),
        .retire         (retire),
        .halted         (halted),
        .fault          (fault),
        .retire_count   (retire_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic scramble_decode();
        insn_is_mem    = 1'($urandom);
        insn_writes_rd = 1'($urandom);
        insn_halt      = 1'($urandom);
        br_taken       = 1'($urandom);
        next_pc        = $urandom;
    endtask

    // Called with rst low at least 1 time unit clear of a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_retire_count", retire_count, 32'd0);
        chk("rst_taken_count", taken_count, 32'd0);
        chk("rst_pulses", {29'd0, retire, rf_we, ir_we & 1'b0}, 32'd0);
        chk("rst_sticky", {30'd0, halted, fault}, 32'd0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        m_pc  = RST_PC;
        m_ret = '0;
        m_tkn = '0;
    endtask

    // Entry: at (or just after) a falling edge with the DUT waiting in fetch.
    task automatic run_insn(input int fw, input bit is_mem, input int mw, input bit rd,
                            input bit tk, input logic [31:0] tgt, input bit hlt);
        for (int i = 0; i < fw; i++) begin
            imem_ready = 1'b0;
            #1;
            chk("stall_imem_req", 32'(imem_req), 32'd1);
            chk("stall_imem_addr", imem_addr, m_pc);
            chk("stall_ir_we", 32'(ir_we), 32'd0);
            @(negedge clk);
        end
        imem_ready = 1'b1;
        #1;
        chk("accept_ir_we", 32'(ir_we), 32'd1);
        chk("accept_imem_addr", imem_addr, m_pc);
        @(negedge clk);
        imem_ready     = 1'($urandom);
        insn_is_mem    = is_mem;
        insn_writes_rd = rd;
        insn_halt      = hlt;
        br_taken       = tk;
        next_pc        = tgt;
        #1;
        chk("exec_ir_we", 32'(ir_we), 32'd0);
        chk("exec_imem_req", 32'(imem_req), 32'd0);
        chk("exec_retire", 32'(retire), 32'd0);
        @(negedge clk);
        scramble_decode();
        if (hlt) begin
            imem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                chk("halt_flag", 32'(halted), 32'd1);
                chk("halt_idle", {29'd0, imem_req, retire, dmem_req}, 32'd0);
                chk("halt_pc", pc, m_pc);
                chk("halt_retire_count", retire_count, m_ret);
                @(negedge clk);
            end
            return;
        end
        if (tgt[1:0] != 2'b00) begin
            imem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                chk("fault_flag", 32'(fault), 32'd1);
                chk("fault_idle", {29'd0, imem_req, retire, dmem_req}, 32'd0);
                chk("fault_pc", pc, m_pc);
                @(negedge clk);
            end
            return;
        end
        if (is_mem) begin
            for (int i = 0; i < mw; i++) begin
                dmem_ready = (i == mw - 1);
                imem_ready = 1'($urandom);
                #1;
                chk("mem_dmem_req", 32'(dmem_req), 32'd1);
                chk("mem_retire", 32'(retire), 32'd0);
                @(negedge clk);
            end
            dmem_ready = 1'b0;
        end
        #1;
        chk("wb_retire", 32'(retire), 32'd1);
        chk("wb_rf_we", 32'(rf_we), 32'(rd));
        chk("wb_dmem_req", 32'(dmem_req), 32'd0);
        chk("wb_pc_old", pc, m_pc);
        @(negedge clk);
        m_pc  = tgt;
        m_ret = m_ret + 32'd1;
        if (tk) m_tkn = m_tkn + 32'd1;
        #1;
        chk("post_pc", pc, m_pc);
        chk("post_imem_addr", imem_addr, m_pc);
        chk("post_imem_req", 32'(imem_req), 32'd1);
        chk("post_retire", 32'(retire), 32'd0);
        chk("post_retire_count", retire_count, m_ret);
        chk("post_taken_count", taken_count, m_tkn);
    endtask

    initial begin
        rst        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        scramble_decode();
        m_pc  = RST_PC;
        m_ret = '0;
        m_tkn = '0;
        #2;
        do_reset();

        // Fetch stall at the reset PC, then a stream of ALU instructions.
        run_insn(5, 1'b0, 0, 1'b1, 1'b0, m_pc + 32'd4, 1'b0);
        for (int i = 0; i < 3; i++) run_insn(0, 1'b0, 0, 1'b1, 1'b0, m_pc + 32'd4, 1'b0);
        chk("pc_at_0x10", pc, 32'h10);

        // Taken branch without register write, then a slow load.
        run_insn(0, 1'b0, 0, 1'b0, 1'b1, 32'h40, 1'b0);
        run_insn(0, 1'b0, 0, 1'b1, 1'b1, 32'h8, 1'b0);
        run_insn(1, 1'b1, 4, 1'b1, 1'b0, 32'hC, 1'b0);
        run_insn(0, 1'b1, 1, 1'b0, 1'b0, m_pc + 32'd4, 1'b0);
        run_insn(0, 1'b0, 0, 1'b1, 1'b0, m_pc, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] t;
            int          sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      t = m_pc;
            else if (sel == 1) t = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            else               t = m_pc + 32'd4;
            run_insn($urandom_range(0, 3), 1'($urandom), $urandom_range(1, 4),
                     1'($urandom), 1'($urandom), t, 1'b0);
        end

        // Misaligned target is terminal; reset recovers.
        run_insn(0, 1'b0, 0, 1'b1, 1'b0, 32'h22, 1'b0);
        #2;
        do_reset();

        run_insn(0, 1'b0, 0, 1'b1, 1'b1, 32'h100, 1'b0);
        run_insn(2, 1'b0, 0, 1'b1, 1'b0, 32'h104, 1'b1);
        #2;
        do_reset();

        // Reset while a data request is outstanding.
        run_insn(0, 1'b0, 0, 1'b1, 1'b0, 32'h4, 1'b0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready     = 1'b0;
        insn_is_mem    = 1'b1;
        insn_halt      = 1'b0;
        next_pc        = 32'h8;
        @(negedge clk);
        #1;
        chk("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
        #1;
        do_reset();
        #1;
        chk("resume_imem_addr", imem_addr, RST_PC);
        chk("resume_imem_req", 32'(imem_req), 32'd1);
        run_insn(0, 1'b0, 0, 1'b1, 1'b0, 32'h4, 1'b0);

        // Counter wrap.
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        m_ret = 32'hFFFF_FFFF;
        chk("preload_retire_count", retire_count, m_ret);
        run_insn(0, 1'b0, 0, 1'b1, 1'b0, m_pc + 32'd4, 1'b0);
        chk("wrapped_retire_count", retire_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
